uart_cmd_tx: RTL and testbench
==============================

# uart_cmd_tx

Parametrised multi-byte UART command transmitter in the UART_CLK domain. It accepts a complete command of 1..MAX_BYTES data words, such as the 0xAA/addr/data write or the 0xCC/op1/op2/fn ALU frame sequence. It serialises the words back-to-back on a single line with programmable bit period, parity and stop-bit count. It drives stimulus into the system RX path and serves as the reusable TX engine for host-side links.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word; valid range 5..9.
- MAX_BYTES, 4, maximum words per command.
- PRESCALE_W, 6, width of the bit-period field.

Ports:
- UART_CLK  in  1  block clock.
- rst  in  1  synchronous reset, active-high.
- PRESCALE  in  PRESCALE_W  UART_CLK cycles per bit (P). The value 0 is treated as 1.
- PAR_EN  in  1  adds a parity bit after the data bits when high.
- PAR_TYP  in  1  selects parity: 0 = even (bit = ^word), 1 = odd (bit = ~^word).
- STOP2  in  1  selects the stop-bit count: 0 = one stop bit, 1 = two stop bits.
- CMD_VLD  in  1  command request.
- CMD_LEN  in  clog2(MAX_BYTES+1)  number of words N in the command.
- CMD_DATA  in  MAX_BYTES*DATA_WIDTH  command payload. Word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. Word 0 is sent first.
- CMD_RDY  out  1  block idle and able to accept a command.
- TX_OUT  out  1  serial line; idles high.
- BUSY  out  1  a command is being transmitted.
- BYTE_DONE  out  1  one-cycle pulse in the last cycle of each word's final stop bit.
- CMD_DONE  out  1  one-cycle pulse in the last cycle of the command's final stop bit.
- ERR_LEN  out  1  one-cycle pulse when a command with an illegal length is rejected.

## Operation
- A command is accepted in a cycle where CMD_VLD && CMD_RDY is high and 1 ≤ CMD_LEN ≤ MAX_BYTES.
- On acceptance, the block latches CMD_DATA, CMD_LEN, PRESCALE, PAR_EN, PAR_TYP and STOP2. Input changes during transmission have no effect.
- If CMD_LEN is 0 or greater than MAX_BYTES, ERR_LEN pulses in the next cycle, the command is not accepted, and the block stays IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on acceptance.
  - START → DATA after P cycles.
  - DATA → PARITY, or DATA → STOP when parity is disabled, after DATA_WIDTH bits of P cycles each.
  - PARITY → STOP after P cycles.
  - STOP → START when words remain. This transition inserts no idle gap between words.
  - STOP → IDLE after the last word.
- Bit order on the line:
  - start bit = 0;
  - data bits, LSB first;
  - parity bit, if enabled;
  - stop bits = 1, one or two of them.
- Frame length is F = 2 + DATA_WIDTH + PAR_EN + STOP2 bits.
- Counters:
  - bit-period counter counts 0..P-1;
  - bit index counter counts 0..DATA_WIDTH-1;
  - word index counter counts 0..N-1;
  - stop counter counts 0..STOP2.
- Parity is computed from the latched word.
- BUSY = 1 in all states except IDLE.
- CMD_RDY = 1 in IDLE when rst is low.

## Timing
- TX_OUT, BUSY, CMD_RDY, BYTE_DONE, CMD_DONE and ERR_LEN are all registered.
- Acceptance occurs in cycle 0:
  - start bit of word 0 drives TX_OUT in cycles 1..P;
  - bit j of the frame for word i occupies cycles (i*F + j)*P + 1 .. (i*F + j + 1)*P.
- BYTE_DONE is high in cycle (i+1)*F*P for each word i.
- CMD_DONE is high in cycle N*F*P, coinciding with the final BYTE_DONE.
- CMD_RDY rises in cycle N*F*P + 1. The earliest next acceptance is in that cycle, which leaves one idle-high cycle between commands.
- BUSY rises in cycle 1 and falls in cycle N*F*P + 1.
- Reset values while rst is high:
  - TX_OUT = 1;
  - BUSY = 0;
  - CMD_RDY = 0;
  - BYTE_DONE = 0;
  - CMD_DONE = 0;
  - ERR_LEN = 0.
- After reset, CMD_RDY = 1 from the first cycle with rst low.
- Reset mid-frame: TX_OUT is high at the next edge, the command is discarded, and no BYTE_DONE or CMD_DONE is issued.
- CMD_VLD held high across CMD_DONE: the same payload is re-accepted in cycle N*F*P + 1. Upstream must drop CMD_VLD after acceptance if only one transmission is intended.
- P = 1 is supported: each bit lasts exactly 1 cycle.

## Test plan
- Write command with P=4, PAR_EN=1, PAR_TYP=0, STOP2=0, N=3, CMD_DATA words 0xAA, 0x00, 0xFF:
  - F = 11, so CMD_DONE occurs in cycle 132;
  - word 0xAA on the line = 0, 0,1,0,1,0,1,0,1, 0, 1;
  - word 0xFF has parity bit 0;
  - BYTE_DONE occurs in cycles 44, 88 and 132.
- Odd parity with two stop bits: P=16, PAR_TYP=1, STOP2=1, N=1, word 0x01:
  - parity bit = 0;
  - two stop bits of 16 cycles each;
  - F = 12, so CMD_DONE occurs in cycle 192.
- Parity disabled, P=0 (treated as 1), N=4, words 0x0A, 0x0B, 0x02, 0xCC:
  - F = 10;
  - no gaps between words;
  - CMD_DONE occurs in cycle 40;
  - CMD_RDY rises in cycle 41.
- Illegal lengths: CMD_LEN = 0, then CMD_LEN = 5 with MAX_BYTES = 4:
  - ERR_LEN pulses once for each request;
  - BUSY stays 0 and TX_OUT stays 1.
- Reset mid-transmission: assert rst in cycle 20 of an N=2 command:
  - TX_OUT = 1 at the next edge;
  - no CMD_DONE;
  - CMD_RDY = 1 after rst is released;
  - a new command then transmits correctly.
- Config change mid-command: toggle PAR_TYP and PRESCALE during transmission:
  - the line waveform matches the configuration latched at acceptance.

Source files
------------

// File: rtl/uart_cmd_tx.sv
// Sends a 1..MAX_BYTES word command as back-to-back UART frames (start, LSB-first data, optional parity, 1-2 stops).
// The line starts one cycle after acceptance. CMD_RDY stays low until the final stop bit has ended.
module uart_cmd_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 4,
  parameter int PRESCALE_W = 6
) (
  input  logic                               UART_CLK,
  input  logic                               rst,
  input  logic [PRESCALE_W-1:0]              PRESCALE,
  input  logic                               PAR_EN,
  input  logic                               PAR_TYP,
  input  logic                               STOP2,
  input  logic                               CMD_VLD,
  input  logic [$clog2(MAX_BYTES+1)-1:0]     CMD_LEN,
  input  logic [MAX_BYTES*DATA_WIDTH-1:0]    CMD_DATA,
  output logic                               CMD_RDY,
  output logic                               TX_OUT,
  output logic                               BUSY,
  output logic                               BYTE_DONE,
  output logic                               CMD_DONE,
  output logic                               ERR_LEN
);

  localparam int LEN_W  = $clog2(MAX_BYTES+1);
  localparam int WIDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH-1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic [PRESCALE_W-1:0] r_cnt, w_cnt_nxt, r_pm1;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic [WIDX_W-1:0]     r_word, w_word_nxt, r_last_word;
  logic                  r_stop, w_stop_nxt;
  logic                  r_par_en, r_par_typ, r_stop2;
  logic [DATA_WIDTH-1:0] r_words [MAX_BYTES];
  logic [DATA_WIDTH-1:0] w_cur_word;
  logic                  w_len_ok, w_accept, w_cnt_last;
  logic                  w_tx_nxt, w_byte_done_nxt, w_cmd_done_nxt;

  assign w_len_ok   = (CMD_LEN != '0) && (CMD_LEN <= LEN_W'(MAX_BYTES));
  assign w_accept   = CMD_VLD && CMD_RDY && w_len_ok;
  assign w_cnt_last = (r_cnt == r_pm1);

  // Everything the line depends on is frozen at acceptance
  always_ff @(posedge UART_CLK) begin
    if (w_accept) begin
      r_pm1       <= (PRESCALE == '0) ? '0 : PRESCALE - 1'b1;
      r_par_en    <= PAR_EN;
      r_par_typ   <= PAR_TYP;
      r_stop2     <= STOP2;
      r_last_word <= WIDX_W'(CMD_LEN - 1'b1);
      for (int i = 0; i < MAX_BYTES; i++) begin
        r_words[i] <= CMD_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_word  <= w_word_nxt;
      r_stop  <= w_stop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_word_nxt  = r_word;
    w_stop_nxt  = r_stop;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_cnt_last ? '0 : r_cnt + 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_word_nxt  = '0;
          w_stop_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          if (r_bit == LAST_BIT) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            w_stop_nxt  = 1'b0;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_cnt_last) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          if (r_stop != r_stop2) begin
            w_stop_nxt = 1'b1;
          end else if (r_word == r_last_word) begin
            w_state_nxt = S_IDLE;
          end else begin
            // next word's start bit follows immediately, no idle gap
            w_state_nxt = S_START;
            w_word_nxt  = r_word + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered copies line up with it
  always_comb begin
    w_cur_word = r_words[w_word_nxt];
    w_tx_nxt   = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_cur_word[w_bit_nxt];
      S_PARITY: w_tx_nxt = r_par_typ ? ~^w_cur_word : ^w_cur_word;
      default:  w_tx_nxt = 1'b1;
    endcase
    w_byte_done_nxt = (w_state_nxt == S_STOP) && (w_stop_nxt == r_stop2) && (w_cnt_nxt == r_pm1);
    w_cmd_done_nxt  = w_byte_done_nxt && (w_word_nxt == r_last_word);
  end

  always_ff @(posedge UART_CLK) begin
    if (rst) begin
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      CMD_RDY   <= 1'b0;
      BYTE_DONE <= 1'b0;
      CMD_DONE  <= 1'b0;
      ERR_LEN   <= 1'b0;
    end else begin
      TX_OUT    <= w_tx_nxt;
      BUSY      <= (w_state_nxt != S_IDLE);
      CMD_RDY   <= (w_state_nxt == S_IDLE);
      BYTE_DONE <= w_byte_done_nxt;
      CMD_DONE  <= w_cmd_done_nxt;
      ERR_LEN   <= CMD_VLD && CMD_RDY && !w_len_ok;
    end
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Scoreboard bench for uart_cmd_tx: per-cycle expected line/pulse records queued by stimulus, popped by a monitor.
module tb_uart_cmd_tx;

  logic        UART_CLK = 1'b0;
  logic        rst;
  logic [5:0]  PRESCALE;
  logic        PAR_EN, PAR_TYP, STOP2, CMD_VLD;
  logic [2:0]  CMD_LEN;
  logic [31:0] CMD_DATA;
  logic        CMD_RDY, TX_OUT, BUSY, BYTE_DONE, CMD_DONE, ERR_LEN;

  uart_cmd_tx #(.DATA_WIDTH(8), .MAX_BYTES(4), .PRESCALE_W(6)) dut (
    .UART_CLK (UART_CLK),
    .rst      (rst),
    .PRESCALE (PRESCALE),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .STOP2    (STOP2),
    .CMD_VLD  (CMD_VLD),
    .CMD_LEN  (CMD_LEN),
    .CMD_DATA (CMD_DATA),
    .CMD_RDY  (CMD_RDY),
    .TX_OUT   (TX_OUT),
    .BUSY     (BUSY),
    .BYTE_DONE(BYTE_DONE),
    .CMD_DONE (CMD_DONE),
    .ERR_LEN  (ERR_LEN)
  );

  always #5 UART_CLK = ~UART_CLK;

  typedef struct packed {
    logic tx;
    logic bd;
    logic cd;
  } rec_t;

  rec_t exp_q[$];
  int   done_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  bit   rdy_next = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // fr holds the hand-built frame, bit 0 first on the line
  task automatic push_frame(input logic [11:0] fr, input int f, input int p);
    rec_t r;
    for (int j = 0; j < f; j++) begin
      for (int k = 0; k < p; k++) begin
        r.tx = fr[j];
        r.bd = (j == f-1) && (k == p-1);
        r.cd = 1'b0;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic issue(input int p, input bit pe, input bit pt, input bit s2,
                       input int n, input logic [31:0] data, input int done_cyc);
    rec_t r;
    r = exp_q.pop_back();
    r.cd = 1'b1;
    exp_q.push_back(r);
    done_q.push_back(done_cyc);
    chk("rdy_before_issue", CMD_RDY, 1);
    PRESCALE = 6'(p); PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
    CMD_LEN  = 3'(n); CMD_DATA = data; CMD_VLD = 1'b1;
    @(negedge UART_CLK);
    CMD_VLD = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge UART_CLK);
      k++;
    end
    chk("cmd_completes", exp_q.size() == 0, 1);
    chk("cmd_done_seen", done_q.size() == 0, 1);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge UART_CLK);
  endtask

  task automatic bad_len(input logic [2:0] len);
    CMD_LEN = len; CMD_DATA = 32'h12345678; CMD_VLD = 1'b1;
    @(negedge UART_CLK);
    CMD_VLD = 1'b0;
    chk("err_len_pulse", ERR_LEN, 1);
    chk("err_busy", BUSY, 0);
    chk("err_tx", TX_OUT, 1);
    @(negedge UART_CLK);
    chk("err_len_single", ERR_LEN, 0);
    chk("err_busy_after", BUSY, 0);
    chk("err_tx_after", TX_OUT, 1);
    chk("err_rdy_after", CMD_RDY, 1);
  endtask

  always @(negedge UART_CLK) begin
    rec_t e;
    int   d;
    if (!mon_en) begin
      cyc = 0;
      rdy_next = 1'b0;
    end else begin
      if (rdy_next) begin
        chk("rdy_busy_after_done", {30'd0, CMD_RDY, BUSY}, 32'd2);
        rdy_next = 1'b0;
      end
      if (BUSY || BYTE_DONE || CMD_DONE) begin
        cyc++;
        chk("queue_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("line_c%0d{tx,bd,cd,rdy}", cyc),
              {28'd0, TX_OUT, BYTE_DONE, CMD_DONE, CMD_RDY},
              {28'd0, e.tx, e.bd, e.cd, 1'b0});
        end
        if (CMD_DONE) begin
          d = (done_q.size() != 0) ? done_q.pop_front() : -1;
          chk("cmd_done_cycle", cyc, d);
          rdy_next = 1'b1;
        end
      end else begin
        cyc = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int hits;
    int lows;
    rst = 1'b1; CMD_VLD = 1'b0; CMD_LEN = '0; CMD_DATA = '0;
    PRESCALE = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    repeat (3) @(negedge UART_CLK);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_rdy", CMD_RDY, 0);
    chk("rst_byte_done", BYTE_DONE, 0);
    chk("rst_cmd_done", CMD_DONE, 0);
    chk("rst_err_len", ERR_LEN, 0);
    rst = 1'b0;
    for (int i = 0; i < 4 && !CMD_RDY; i++) @(negedge UART_CLK);
    chk("rdy_after_reset", CMD_RDY, 1);
    mon_en = 1'b1;

    // P=4, even parity, 1 stop, words AA 00 FF: F=11, done at 132
    push_frame({1'b1, 1'b0, 8'hAA, 1'b0}, 11, 4);
    push_frame({1'b1, 1'b0, 8'h00, 1'b0}, 11, 4);
    push_frame({1'b1, 1'b0, 8'hFF, 1'b0}, 11, 4);
    issue(4, 1, 0, 0, 3, 32'h00FF00AA, 132);
    wait_idle();

    // P=16, odd parity, 2 stops, word 01: parity 0, F=12, done at 192
    push_frame({2'b11, 1'b0, 8'h01, 1'b0}, 12, 16);
    issue(16, 1, 1, 1, 1, 32'h00000001, 192);
    wait_idle();

    // P=0 behaves as 1, no parity, four words: F=10, done at 40
    push_frame({1'b1, 8'h0A, 1'b0}, 10, 1);
    push_frame({1'b1, 8'h0B, 1'b0}, 10, 1);
    push_frame({1'b1, 8'h02, 1'b0}, 10, 1);
    push_frame({1'b1, 8'hCC, 1'b0}, 10, 1);
    issue(0, 0, 0, 0, 4, 32'hCC020B0A, 40);
    wait_idle();

    bad_len(3'd0);
    bad_len(3'd5);

    // Reset in cycle 20 of a P=2, N=2 command; cycle 20 carries word 0x03's even parity bit (0)
    mon_en = 1'b0;
    PRESCALE = 6'd2; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    CMD_LEN = 3'd2; CMD_DATA = 32'h00004403; CMD_VLD = 1'b1;
    @(negedge UART_CLK);
    CMD_VLD = 1'b0;
    chk("mid_start_bit", TX_OUT, 0);
    chk("mid_busy", BUSY, 1);
    repeat (19) @(negedge UART_CLK);
    chk("mid_parity_c20", TX_OUT, 0);
    rst = 1'b1;
    @(negedge UART_CLK);
    chk("mid_rst_tx", TX_OUT, 1);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_rdy", CMD_RDY, 0);
    @(negedge UART_CLK);
    rst = 1'b0;
    hits = 0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge UART_CLK);
      if (BYTE_DONE || CMD_DONE) hits++;
      if (!TX_OUT) lows++;
    end
    chk("mid_no_done_pulses", hits, 0);
    chk("mid_line_idle", lows, 0);
    chk("mid_rdy_after_release", CMD_RDY, 1);
    mon_en = 1'b1;

    push_frame({1'b1, 1'b0, 8'h81, 1'b0}, 11, 2);
    issue(2, 1, 0, 0, 1, 32'h00000081, 22);
    wait_idle();

    // Config scrambled right after acceptance; line must follow the latched P=3, odd parity, 1 stop
    push_frame({1'b1, 1'b1, 8'h5A, 1'b0}, 11, 3);
    push_frame({1'b1, 1'b1, 8'h3C, 1'b0}, 11, 3);
    issue(3, 1, 1, 0, 2, 32'h00003C5A, 66);
    PRESCALE = 6'd9; PAR_TYP = 1'b0; PAR_EN = 1'b0; STOP2 = 1'b1; CMD_DATA = 32'hFFFFFFFF;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
